// File: rtl/exec_sequencer.sv
// Y86 SEQ execute-stage sequencer: operand select, valE capture, CC register, cnd evaluation.
// Optional EXEC_PERF_EN adds perf_instr / perf_stall counters.
module exec_sequencer #(
    parameter int unsigned W          = 64,
    parameter int unsigned STACK_STEP = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   icode,
    input  logic [3:0]   ifun,
    input  logic [W-1:0] valA,
    input  logic [W-1:0] valB,
    input  logic [W-1:0] valC,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [1:0]   alu_fun,
    input  logic [W-1:0] alu_result,
    input  logic [2:0]   alu_flags,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] valE,
    output logic         cnd,
    output logic [2:0]   cc,
    output logic [2:0]   stat
`ifdef EXEC_PERF_EN
    ,
    output logic [31:0]  perf_instr,
    output logic [31:0]  perf_stall
`endif
);

    typedef enum logic [1:0] {StIdle, StExec, StResp, StHalted} state_e;

    localparam logic [3:0] IcHalt  = 4'h0;
    localparam logic [3:0] IcRrmov = 4'h2;
    localparam logic [3:0] IcIrmov = 4'h3;
    localparam logic [3:0] IcRmmov = 4'h4;
    localparam logic [3:0] IcMrmov = 4'h5;
    localparam logic [3:0] IcOpq   = 4'h6;
    localparam logic [3:0] IcJxx   = 4'h7;
    localparam logic [3:0] IcCall  = 4'h8;
    localparam logic [3:0] IcRet   = 4'h9;
    localparam logic [3:0] IcPush  = 4'hA;
    localparam logic [3:0] IcPop   = 4'hB;

    localparam logic [2:0] StatAok = 3'd1;
    localparam logic [2:0] StatHlt = 3'd2;
    localparam logic [2:0] StatIns = 3'd4;

    localparam logic [1:0] AluAdd = 2'd0;

    localparam logic [W-1:0] PosStep = W'(STACK_STEP);
    localparam logic [W-1:0] NegStep = '0 - W'(STACK_STEP);

    state_e         state_q, state_d;
    logic [3:0]     icode_q, ifun_q;
    logic [W-1:0]   alu_a_q, alu_b_q, vale_q;
    logic [1:0]     alu_fun_q;
    logic           cnd_q;
    logic [2:0]     cc_q, stat_q;

    logic [W-1:0]   sel_a, sel_b;
    logic [1:0]     sel_fun;
    logic           accept;
    logic           ins;
    logic [2:0]     exec_stat;
    logic           cond;
    logic           exec_cnd;
    logic           zf, sf, of;

    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_fun = alu_fun_q;
    assign valE    = vale_q;
    assign cnd     = cnd_q;
    assign cc      = cc_q;
    assign stat    = stat_q;

    assign zf = cc_q[2];
    assign sf = cc_q[1];
    assign of = cc_q[0];

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_fun = AluAdd;
        case (icode)
            IcOpq: begin
                sel_a   = valA;
                sel_b   = valB;
                sel_fun = ifun[1:0];
            end
            IcRrmov:         sel_a = valA;
            IcIrmov:         sel_a = valC;
            IcRmmov, IcMrmov: begin
                sel_a = valC;
                sel_b = valB;
            end
            IcCall, IcPush: begin
                sel_a = NegStep;
                sel_b = valB;
            end
            IcRet, IcPop: begin
                sel_a = PosStep;
                sel_b = valB;
            end
            default: ;
        endcase
    end

    // Status and condition are evaluated on the latched instruction against pre-EXEC flags.
    always_comb begin
        ins = (icode_q > IcPop)
            || (icode_q == IcOpq && ifun_q > 4'd3)
            || ((icode_q == IcRrmov || icode_q == IcJxx) && ifun_q > 4'd6);
        if (ins)                    exec_stat = StatIns;
        else if (icode_q == IcHalt) exec_stat = StatHlt;
        else                        exec_stat = StatAok;

        cond = 1'b0;
        case (ifun_q)
            4'd0: cond = 1'b1;
            4'd1: cond = (sf ^ of) | zf;
            4'd2: cond = sf ^ of;
            4'd3: cond = zf;
            4'd4: cond = ~zf;
            4'd5: cond = ~(sf ^ of);
            4'd6: cond = ~(sf ^ of) & ~zf;
            default: cond = 1'b0;
        endcase
        exec_cnd = (icode_q == IcRrmov || icode_q == IcJxx) && !ins && cond;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) state_d = StExec;
            end
            StExec: state_d = StResp;
            StResp: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    // A faulting instruction must not let a successor slip in.
                    if (stat_q != StatAok) begin
                        state_d = StHalted;
                    end else begin
                        in_ready = 1'b1;
                        state_d  = in_valid ? StExec : StIdle;
                    end
                end
            end
            StHalted: ;
            default: state_d = StIdle;
        endcase
        accept = in_valid & in_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            icode_q   <= '0;
            ifun_q    <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_fun_q <= AluAdd;
            vale_q    <= '0;
            cnd_q     <= 1'b0;
            cc_q      <= 3'b100;
            stat_q    <= StatAok;
        end else begin
            state_q <= state_d;
            if (accept) begin
                icode_q   <= icode;
                ifun_q    <= ifun;
                alu_a_q   <= sel_a;
                alu_b_q   <= sel_b;
                alu_fun_q <= sel_fun;
            end
            if (state_q == StExec) begin
                vale_q <= alu_result;
                cnd_q  <= exec_cnd;
                stat_q <= exec_stat;
                if (icode_q == IcOpq && exec_stat == StatAok) cc_q <= alu_flags;
            end
        end
    end

`ifdef EXEC_PERF_EN
    logic [31:0] perf_instr_q, perf_stall_q;

    assign perf_instr = perf_instr_q;
    assign perf_stall = perf_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_instr_q <= '0;
            perf_stall_q <= '0;
        end else if (state_q == StResp) begin
            if (out_ready) perf_instr_q <= perf_instr_q + 32'd1;
            else           perf_stall_q <= perf_stall_q + 32'd1;
        end
    end
`endif

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Multi-cycle controller that sequences the Y86 SEQ execute-stage ALU.
- Accepts one decoded instruction (icode, ifun, valA, valB, valC) over a valid/ready handshake and selects ALU operands and function.
- Captures valE, owns the architectural condition-code register (ZF, SF, OF) and evaluates cnd for cmovXX/jXX.
- Returns the result over a second valid/ready handshake and sits between decode and memory/write-back.

Parameters:
- W, 64, datapath width of valA/valB/valC/valE.
- STACK_STEP, 8, stack-pointer adjustment for call/ret/pushq/popq.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  sequencer accepts the instruction this cycle
- icode  in  4  instruction code
- ifun  in  4  function code
- valA, valB, valC  in  W each  operands
- alu_a, alu_b  out  W each  ALU operands (registered)
- alu_fun  out  2  0=add, 1=sub(b-a), 2=and, 3=xor
- alu_result  in  W  ALU result, combinational from alu_a/alu_b/alu_fun
- alu_flags  in  3  {ZF,SF,OF} of alu_result
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- valE  out  W  captured ALU result
- cnd  out  1  condition outcome
- cc  out  3  current {ZF,SF,OF}
- stat  out  3  1=AOK, 2=HLT, 4=INS

Behaviour:
- States: IDLE, EXEC, RESP, HALTED.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0.
  - alu_a=alu_b=0, alu_fun=0, valE=0, cnd=0.
  - cc=3'b100 (ZF=1), stat=1.
- in_ready = (state==IDLE) | (state==RESP & out_ready). A handshake occurs when in_valid & in_ready.
- On a handshake, latch icode/ifun and drive operands from the next edge, then go to EXEC.
- Operand selection (a, b, fun):
  - 6 OPq: (valA, valB, ifun[1:0])
  - 2 rrmovq/cmovXX: (valA, 0, add)
  - 3 irmovq: (valC, 0, add)
  - 4 rmmovq, 5 mrmovq: (valC, valB, add)
  - 8 call, A pushq: (-STACK_STEP, valB, add)
  - 9 ret, B popq: (STACK_STEP, valB, add)
  - 0 halt, 1 nop, 7 jXX: (0, 0, add)
- EXEC lasts exactly one cycle:
  - Capture valE<=alu_result.
  - Compute cnd from the cc value held before this instruction. ifun mapping:
    - 0: 1
    - 1 le: (SF^OF)|ZF
    - 2 l: SF^OF
    - 3 e: ZF
    - 4 ne: ~ZF
    - 5 ge: ~(SF^OF)
    - 6 g: ~(SF^OF)&~ZF
  - cnd=0 for all icodes other than 2 and 7.
  - cc<=alu_flags only when icode==6 and stat is AOK.
  - Go to RESP.
- Latency: handshake edge to out_valid = 2 cycles. Back-to-back throughput is 1 instruction per 2 cycles (RESP→EXEC when out_ready & in_valid).
- RESP: out_valid=1. valE/cnd/stat are held stable until out_ready. On out_ready:
  - stat==AOK: go to EXEC if in_valid was accepted the same cycle, else IDLE.
  - stat!=AOK: go to HALTED.
- Status:
  - icode 0 → stat=HLT.
  - icode>0xB, icode 6 with ifun>3, or icode 2/7 with ifun>6 → stat=INS, cc unchanged, cnd=0.
- HALTED: in_ready=0, out_valid=0, all outputs frozen. Left only by rst.
- cc is updated before the dependent instruction's EXEC. An OPq immediately followed by jXX sees the new flags, with no bubble.
- rst mid-operation (any state) aborts the instruction. No response is produced and all registers return to reset values.
- in_valid while in_ready=0 is ignored. The producer holds the instruction.

Optional Feature:
- Macro EXEC_PERF_EN.
- Defined: adds outputs perf_instr (32, count of completed RESP handshakes) and perf_stall (32, cycles in RESP with out_ready=0).
  - Both counters wrap at 2^32 and clear on rst.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then OPq add (icode 6, ifun 0, valA=0x45, valB=0x45) → alu_a=alu_b=0x45. out_valid 2 cycles after the handshake with valE=0x8A, cc=3'b000, stat=1.
- OPq sub (ifun 1, valA=0x45, valB=-0x45), then jXX le (icode 7, ifun 1) → first valE=-0x8A, cc SF=1. jXX cnd=1 with no bubble between the two.
- rmmovq (valC=0x11, valB=0x45) with out_ready held low 3 cycles → valE=0x56 stable throughout, in_ready=0, out_valid held.
- pushq valB=0x100, then popq valB=0xF8 → valE=0xF8, then valE=0x100. cc unchanged (ZF=1 after reset).
- icode 0xC → stat=4, cc unchanged. After out_ready the sequencer enters HALTED; in_ready stays 0 for 10 cycles. rst returns it to IDLE.
- rst asserted during EXEC of an OPq → no out_valid, cc=3'b100, valE=0 on the next cycle.
